// File: rtl/complex_mult_pipe.sv
// complex_mult_pipe: 3-multiplier pipelined complex multiply with conjugate, round/shift, saturation and valid/ready
module complex_mult_pipe #(
  parameter int IN1_W = 18,
  parameter int IN2_W = 20,
  parameter int FRAC_SHIFT = 18,
  parameter int OUT_W = 24,
  parameter bit ROUND_EN = 1'b1,
  parameter bit SAT_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic conj,
  input  logic signed [IN1_W-1:0] in1_real,
  input  logic signed [IN1_W-1:0] in1_imag,
  input  logic signed [IN2_W-1:0] in2_real,
  input  logic signed [IN2_W-1:0] in2_imag,
  output logic out_valid,
  input  logic out_ready,
  output logic signed [OUT_W-1:0] out_real,
  output logic signed [OUT_W-1:0] out_imag,
  output logic out_ovf,
  output logic ovf_sticky
);
  localparam int FW = IN1_W + IN2_W + 3;
  localparam logic signed [FW-1:0] RND = (ROUND_EN && FRAC_SHIFT > 0) ? FW'(1) << (FRAC_SHIFT > 0 ? FRAC_SHIFT - 1 : 0) : '0;
  function automatic logic [OUT_W:0] scale(input logic signed [FW-1:0] x);
    logic signed [FW-1:0] s;
    logic fit;
    s = (x + RND) >>> FRAC_SHIFT;
    fit = &s[FW-1:OUT_W-1] || !(|s[FW-1:OUT_W-1]);
    scale = {!fit, (fit || !SAT_EN) ? s[OUT_W-1:0] : {s[FW-1], {(OUT_W-1){!s[FW-1]}}}};
  endfunction
  logic en, v1, v2;
  logic signed [IN2_W:0] d;
  logic signed [IN1_W-1:0] a1, b1;
  logic signed [IN2_W-1:0] c1;
  logic signed [IN1_W:0] ab1;
  logic signed [IN2_W+1:0] cd1, dc1;
  logic signed [FW-3:0] k1;
  logic signed [FW-2:0] k2, k3;
  logic signed [FW-1:0] re, im;
  logic [OUT_W:0] sr, si;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign d = conj ? -(IN2_W+1)'(in2_imag) : (IN2_W+1)'(in2_imag);
  assign re = FW'(k1) - FW'(k3);
  assign im = FW'(k1) + FW'(k2);
  assign sr = scale(re);
  assign si = scale(im);
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_real <= '0;
      out_imag <= '0;
      out_ovf <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_ovf) ovf_sticky <= 1'b1;
      if (en) begin
        v1 <= in_valid;
        a1 <= in1_real;
        b1 <= in1_imag;
        c1 <= in2_real;
        ab1 <= (IN1_W+1)'(in1_real) + (IN1_W+1)'(in1_imag);
        cd1 <= (IN2_W+2)'(in2_real) + (IN2_W+2)'(d);
        dc1 <= (IN2_W+2)'(d) - (IN2_W+2)'(in2_real);
        v2 <= v1;
        k1 <= (FW-2)'(c1) * (FW-2)'(ab1);
        k2 <= (FW-1)'(a1) * (FW-1)'(dc1);
        k3 <= (FW-1)'(b1) * (FW-1)'(cd1);
        out_valid <= v2;
        out_real <= sr[OUT_W-1:0];
        out_imag <= si[OUT_W-1:0];
        out_ovf <= sr[OUT_W] || si[OUT_W];
      end
    end
  end
endmodule

// File: tb/tb_complex_mult_pipe.sv
// tb_complex_mult_pipe: directed table-driven bench for complex_mult_pipe
module tb_complex_mult_pipe;
  typedef struct {
    logic signed [17:0] a, b;
    logic signed [19:0] c, d;
    logic cj;
    logic signed [23:0] r0, i0, r1, i1;
    logic signed [17:0] r2, i2;
    logic o2;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, conj = 1'b0;
  logic signed [17:0] a = '0, b = '0;
  logic signed [19:0] c = '0, d = '0;
  logic [2:0] irdy, ovl, ovf, stk;
  logic signed [23:0] r0, i0, r1, i1;
  logic signed [17:0] r2, i2;
  int checks = 0, errors = 0;
  vec_t tv [7];
  always #5 clk = ~clk;
  complex_mult_pipe u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .conj(conj),
    .in1_real(a), .in1_imag(b), .in2_real(c), .in2_imag(d), .out_valid(ovl[0]), .out_ready(out_ready),
    .out_real(r0), .out_imag(i0), .out_ovf(ovf[0]), .ovf_sticky(stk[0]));
  complex_mult_pipe #(.ROUND_EN(1'b0)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .conj(conj),
    .in1_real(a), .in1_imag(b), .in2_real(c), .in2_imag(d), .out_valid(ovl[1]), .out_ready(out_ready),
    .out_real(r1), .out_imag(i1), .out_ovf(ovf[1]), .ovf_sticky(stk[1]));
  complex_mult_pipe #(.OUT_W(18)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .conj(conj),
    .in1_real(a), .in1_imag(b), .in2_real(c), .in2_imag(d), .out_valid(ovl[2]), .out_ready(out_ready),
    .out_real(r2), .out_imag(i2), .out_ovf(ovf[2]), .ovf_sticky(stk[2]));
  function automatic vec_t mk(int a_, int b_, int c_, int d_, int cj_, int r0_, int i0_, int r1_, int i1_, int r2_, int i2_, int o2_);
    vec_t v;
    v.a = 18'(a_);
    v.b = 18'(b_);
    v.c = 20'(c_);
    v.d = 20'(d_);
    v.cj = 1'(cj_);
    v.r0 = 24'(r0_);
    v.i0 = 24'(i0_);
    v.r1 = 24'(r1_);
    v.i1 = 24'(i1_);
    v.r2 = 18'(r2_);
    v.i2 = 18'(i2_);
    v.o2 = 1'(o2_);
    return v;
  endfunction
  task automatic chk(input string n, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_out(output int n);
    n = 1;
    while (!ovl[0] && n < 10) begin
      tick();
      n++;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, sent, rcv, stall;
    bit started;
    tv[0] = mk(1000, -500, 262144, 0, 0, 1000, -500, 1000, -500, 1000, -500, 0);
    tv[1] = mk(100, 200, 0, 262144, 0, -200, 100, -200, 100, -200, 100, 0);
    tv[2] = mk(100, 200, 0, 262144, 1, 200, -100, 200, -100, 200, -100, 0);
    tv[3] = mk(3, -3, 131072, 0, 0, 2, -1, 1, -2, 2, -1, 0);
    tv[4] = mk(-131072, -131072, -524288, -524288, 0, 0, 524288, 0, 524288, 0, 131071, 1);
    tv[5] = mk(-131072, -131072, -524288, -524288, 1, 524288, 0, 524288, 0, 131071, 0, 1);
    tv[6] = mk(-131072, 0, 524287, 0, 0, -262143, 0, -262144, 0, -131072, 0, 1);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out_valid", ovl, 0);
    chk("reset_in_ready", irdy, 7);
    chk("reset_out_real", r0, 0);
    chk("reset_out_imag", i0, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_sticky", stk, 0);
    for (int i = 0; i < 7; i++) begin
      a = tv[i].a;
      b = tv[i].b;
      c = tv[i].c;
      d = tv[i].d;
      conj = tv[i].cj;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(n);
      chk($sformatf("v%0d_latency", i), n, 3);
      chk($sformatf("v%0d_valid", i), ovl, 7);
      chk($sformatf("v%0d_re_round", i), r0, tv[i].r0);
      chk($sformatf("v%0d_im_round", i), i0, tv[i].i0);
      chk($sformatf("v%0d_re_trunc", i), r1, tv[i].r1);
      chk($sformatf("v%0d_im_trunc", i), i1, tv[i].i1);
      chk($sformatf("v%0d_re_sat", i), r2, tv[i].r2);
      chk($sformatf("v%0d_im_sat", i), i2, tv[i].i2);
      chk($sformatf("v%0d_ovf_wide", i), ovf[1:0], 0);
      chk($sformatf("v%0d_ovf_sat", i), ovf[2], tv[i].o2);
      tick();
      chk($sformatf("v%0d_sticky_sat", i), stk[2], i >= 4);
      chk($sformatf("v%0d_sticky_wide", i), stk[1:0], 0);
    end
    a = 100;
    b = 200;
    c = 0;
    d = 262144;
    conj = 1'b0;
    in_valid = 1'b1;
    tick();
    conj = 1'b1;
    tick();
    in_valid = 1'b0;
    conj = 1'b0;
    n = 0;
    while (!ovl[0] && n < 10) begin
      tick();
      n++;
    end
    chk("b2b_first_valid", ovl[0], 1);
    chk("b2b_first_re", r0, -200);
    chk("b2b_first_im", i0, 100);
    tick();
    chk("b2b_second_valid", ovl[0], 1);
    chk("b2b_second_re", r0, 200);
    chk("b2b_second_im", i0, -100);
    tick();
    sent = 0;
    rcv = 0;
    stall = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      if (!started && ovl[0]) begin
        started = 1'b1;
        stall = 4;
      end
      out_ready = stall == 0;
      if (stall > 0) stall--;
      in_valid = sent < 6;
      a = 18'(10 * sent + 1);
      b = 18'(10 * sent + 2);
      c = 0;
      d = 262144;
      #1;
      if (ovl[0]) begin
        chk($sformatf("bp%0d_re", rcv), r0, -(10 * rcv + 2));
        chk($sformatf("bp%0d_im", rcv), i0, 10 * rcv + 1);
        if (out_ready) rcv++;
        else chk("bp_in_ready_low", irdy[0], 0);
      end
      if (in_valid && irdy[0]) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_stall_seen", started, 1);
    chk("bp_sent", sent, 6);
    chk("bp_received", rcv, 6);
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_extra", ovl[0], 0);
      tick();
    end
    a = 5;
    b = 6;
    c = 262144;
    d = 0;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", ovl, 0);
    chk("rst_mid_re", r0, 0);
    chk("rst_mid_im", i0, 0);
    chk("rst_mid_ovf", ovf, 0);
    chk("rst_mid_sticky", stk, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_stale", ovl, 0);
    end
    a = 7;
    b = -9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(n);
    chk("post_rst_latency", n, 3);
    chk("post_rst_re", r0, 7);
    chk("post_rst_im", i0, -9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
